dmem_responder: RTL and testbench

//  Responder end of the CPU data-memory port. Accepts one load/store request at a

---
 rtl/mem_pkg.sv | 30 +++
 rtl/dmem_bram.sv | 43 ++++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Definitions shared by the data-memory responder and the CPU store decode:
//   responder FSM state encoding, byte-lane geometry, the standard store masks
//   (byte / half / word) and an address range helper.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int WORD_W    = LANE_W * NUM_LANES;

    // Byte-write masks as produced by the CPU for SB / SH / SW at lane 0.
    localparam logic [NUM_LANES-1:0] WEN_SB = 4'b0001;
    localparam logic [NUM_LANES-1:0] WEN_SH = 4'b0011;
    localparam logic [NUM_LANES-1:0] WEN_SW = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memState_t;

    // True when the byte address lands inside a 2**depthLog2-word array,
    // i.e. every address bit above the word index is zero.
    function automatic logic addrInRange(input logic [31:0] addr, input int depthLog2);
        return (addr >> (depthLog2 + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// -----------------------------------------------------------------------------
// dmem_bram
//   Single-port synchronous RAM, 2**DEPTH_LOG2 x 32 bits, with one write enable
//   per byte lane and a registered read port (data one cycle after re).
// Ports
//   clk    in   clock, all state on rising edge
//   addr   in   word index, shared by read and write
//   we     in   byte-lane write enables; lane i writes wdata[8i+7:8i]
//   re     in   read enable; rdata updates only when set
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
// -----------------------------------------------------------------------------
module dmem_bram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
)(
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [NUM_LANES-1:0]  we,
    input  logic                  re,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: neither the array nor its read register has a reset; that keeps
    // this mappable onto block RAM, and the responder masks rdata until a load completes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we[i]) begin
                mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder end of the CPU data-memory port. Accepts one load/store at a time,
//   waits LATENCY cycles, then answers with read data or a store ack. Holds the
//   pipeline through stall_o while an access is outstanding.
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   req_i      in   request valid, held by the CPU until addr_ok_o
//   wr_i       in   1 = store, 0 = load
//   wen_i      in   byte-write mask for stores
//   addr_i     in   byte address, [1:0] ignored
//   wdata_i    in   store data, lanes already positioned
//   addr_ok_o  out  request accepted this cycle (combinational)
//   data_ok_o  out  one-cycle response pulse
//   rdata_o    out  load data, valid with data_ok_o, held until next response
//   err_o      out  out-of-range access, pulses with data_ok_o
//   stall_o    out  access pending without a response yet
// -----------------------------------------------------------------------------
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 wr_i,
    input  logic [NUM_LANES-1:0] wen_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 addr_ok_o,
    output logic                 data_ok_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 stall_o
);

    if (LATENCY > 15) begin : gLatencyRange
        $error("dmem_responder: LATENCY must be in 0..15 (4-bit wait counter)");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 30) begin : gDepthRange
        $error("dmem_responder: DEPTH_LOG2 must be in 1..30");
    end

    typedef struct packed {
        logic                  wr;
        logic [NUM_LANES-1:0]  wen;
        logic [DEPTH_LOG2-1:0] word;
        logic [WORD_W-1:0]     wdata;
        logic                  err;
    } capture_t;

    memState_t             state;
    memState_t             nextState;
    logic [3:0]            count;
    capture_t              cap;
    logic                  respLoad;   // last response was an in-range load
    logic                  reqErr;
    logic                  accept;
    logic                  issueLoad;
    logic                  ramRe;
    logic [NUM_LANES-1:0]  ramWe;
    logic [DEPTH_LOG2-1:0] ramAddr;
    logic [WORD_W-1:0]     ramQ;

    assign reqErr = !addrInRange(addr_i, DEPTH_LOG2);
    assign accept = (state == IDLE) && req_i;

    // ---------------- state register ----------------
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned and a latch can never be inferred.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (req_i) nextState = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (count == 4'd1) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        addr_ok_o = 1'b0;
        data_ok_o = 1'b0;
        err_o     = 1'b0;
        stall_o   = 1'b0;
        case (state)
            IDLE: begin
                addr_ok_o = req_i;
                stall_o   = req_i;
            end
            WAIT: stall_o = 1'b1;
            RESP: begin
                data_ok_o = 1'b1;
                err_o     = cap.err;
            end
            default: ;
        endcase
    end

    // ---------------- wait counter and request capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
            cap   <= '0;
        end else if (accept) begin
            count <= 4'(LATENCY);
            cap   <= '{wr: wr_i, wen: wen_i, word: addr_i[DEPTH_LOG2+1:2],
                       wdata: wdata_i, err: reqErr};
        end else if (state == WAIT) begin
            count <= count - 4'd1;
        end
    end

    // ---------------- RAM port control ----------------
    // The read is issued on the edge that enters RESP. From IDLE that is the
    // accept edge (LATENCY==0), so the live request is used before capture.
    assign ramAddr   = (state == IDLE) ? addr_i[DEPTH_LOG2+1:2] : cap.word;
    assign issueLoad = (state == IDLE) ? (!wr_i && !reqErr) : (!cap.wr && !cap.err);
    assign ramRe     = (nextState == RESP) && issueLoad;

    // Stores commit on the RESP->IDLE edge, so a load accepted in the following
    // IDLE cycle already sees the new data. Out-of-range stores are dropped.
    assign ramWe = (state == RESP && cap.wr && !cap.err) ? cap.wen : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            respLoad <= 1'b0;
        end else if (nextState == RESP) begin
            respLoad <= ramRe;
        end
    end

    // Stores and errors answer with zero; the RAM read register holds the
    // load data until the next load, giving the hold-until-next-response view.
    assign rdata_o = respLoad ? ramQ : '0;

    dmem_bram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uBram (
        .clk   (clk),
        .addr  (ramAddr),
        .we    (ramWe),
        .re    (ramRe),
        .wdata (cap.wdata),
        .rdata (ramQ)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Two responders share the stimulus bus: dutL2 (LATENCY=2) and dutL0
//   (LATENCY=0). 'sel' routes req_i to one of them and picks which outputs are
//   observed. A word-array model per instance supplies expected read data.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel = 1'b0;      // 0: LATENCY=2 instance, 1: LATENCY=0 instance
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        req2, req0;
    logic        addrOk2, dataOk2, err2, stall2;
    logic        addrOk0, dataOk0, err0, stall0;
    logic [31:0] rdata2, rdata0;
    logic        addrOk, dataOk, err, stall;
    logic [31:0] rdata;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [31:0] modelMem [2][1024];
    bit          known    [2][1024];
    logic [31:0] lastRdata [2] = '{32'h0, 32'h0};
    bit          lastValid [2] = '{1'b1, 1'b1};

    assign req2   = req & ~sel;
    assign req0   = req & sel;
    assign addrOk = sel ? addrOk0 : addrOk2;
    assign dataOk = sel ? dataOk0 : dataOk2;
    assign err    = sel ? err0    : err2;
    assign stall  = sel ? stall0  : stall2;
    assign rdata  = sel ? rdata0  : rdata2;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dutL2 (
        .clk(clk), .rst(rst), .req_i(req2), .wr_i(wr), .wen_i(wen),
        .addr_i(addr), .wdata_i(wdata), .addr_ok_o(addrOk2), .data_ok_o(dataOk2),
        .rdata_o(rdata2), .err_o(err2), .stall_o(stall2)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dutL0 (
        .clk(clk), .rst(rst), .req_i(req0), .wr_i(wr), .wen_i(wen),
        .addr_i(addr), .wdata_i(wdata), .addr_ok_o(addrOk0), .data_ok_o(dataOk0),
        .rdata_o(rdata0), .err_o(err0), .stall_o(stall0)
    );

    // One complete access on the selected instance, checked cycle by cycle
    // against the expected latency and the word-array model.
    task automatic doAccess(input bit isWr, input logic [3:0] mask, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
        int          lat;
        int          waited;
        int          word;
        bit          expErr;
        bit          checkData;
        logic [31:0] expRdata;
        lat       = sel ? 0 : 2;
        expErr    = (a >= 32'h0000_1000);       // 1K words = 4 KB
        word      = int'(a[11:2]);
        expRdata  = 32'h0;
        checkData = 1'b1;
        if (!isWr && !expErr) begin
            expRdata  = modelMem[sel][word];
            checkData = known[sel][word];
        end

        @(negedge clk);
        if (lastValid[sel]) begin
            totalCnt++;
            if (rdata !== lastRdata[sel])
                $display("FAIL %s rdata_hold: got %h want %h", tag, rdata, lastRdata[sel]);
            else passCnt++;
        end
        req = 1'b1; wr = isWr; wen = mask; addr = a; wdata = d;
        #1;
        waited = 0;
        while (addrOk !== 1'b1 && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        totalCnt++;
        if (addrOk !== 1'b1 || stall !== 1'b1 || dataOk !== 1'b0 || waited != 0) begin
            $display("FAIL %s accept: addr_ok_o=%b stall_o=%b data_ok_o=%b after %0d cycles, want 1 1 0 after 0",
                     tag, addrOk, stall, dataOk, waited);
            req = 1'b0;
            return;
        end
        passCnt++;

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
            totalCnt++;
            if (k <= lat) begin
                if ({addrOk, dataOk, stall} !== 3'b001)
                    $display("FAIL %s wait_cycle%0d: {addr_ok,data_ok,stall}=%b want 001",
                             tag, k, {addrOk, dataOk, stall});
                else passCnt++;
            end else begin
                if ({addrOk, dataOk, stall, err} !== {3'b010, expErr})
                    $display("FAIL %s response: {addr_ok,data_ok,stall,err}=%b want %b",
                             tag, {addrOk, dataOk, stall, err}, {3'b010, expErr});
                else passCnt++;
                if (checkData) begin
                    totalCnt++;
                    if (rdata !== expRdata)
                        $display("FAIL %s rdata: got %h want %h", tag, rdata, expRdata);
                    else passCnt++;
                end
            end
        end

        if (isWr && !expErr) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) modelMem[sel][word][8*i +: 8] = d[8*i +: 8];
            if (mask == 4'hF) known[sel][word] = 1'b1;
        end
        lastRdata[sel] = expRdata;
        lastValid[sel] = checkData;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            totalCnt++;
            if ({addrOk, dataOk, err, stall} !== 4'b0000 || rdata !== 32'h0)
                $display("FAIL reset_outputs inst%0d: {addr_ok,data_ok,err,stall}=%b rdata=%h want 0000 0",
                         s, {addrOk, dataOk, err, stall}, rdata);
            else passCnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        sel = 1'b0;
    endtask

    task automatic test_store_load();
        sel = 1'b0;
        doAccess(1'b1, WEN_SW, 32'h0000_0100, 32'h1234_5678, "t1_store");
        doAccess(1'b0, 4'h0,   32'h0000_0100, 32'h0,         "t1_load");
    endtask

    task automatic test_byte_lanes();
        sel = 1'b0;
        doAccess(1'b1, WEN_SB,  32'h0000_0100, 32'h0000_00AB, "t2_sb_lane0");
        doAccess(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_CD00, "t2_sb_lane1");
        doAccess(1'b0, 4'h0,    32'h0000_0100, 32'h0,         "t2_merge_load");
        doAccess(1'b1, 4'b0000, 32'h0000_0100, 32'hFFFF_FFFF, "t2_noop_store");
        doAccess(1'b0, 4'h0,    32'h0000_0102, 32'h0,         "t2_after_noop");
        doAccess(1'b1, WEN_SH << 2, 32'h0000_0100, 32'h9988_0000, "t2_sh_upper");
        doAccess(1'b0, 4'h0,    32'h0000_0100, 32'h0,         "t2_sh_load");
    endtask

    task automatic test_out_of_range();
        sel = 1'b0;
        doAccess(1'b1, WEN_SW, 32'h0000_0000, 32'hCAFE_F00D, "t4_word0_init");
        doAccess(1'b0, 4'h0,   32'h0000_1000, 32'h0,         "t4_oor_load");
        doAccess(1'b1, WEN_SW, 32'h0000_1000, 32'h1111_1111, "t4_oor_store");
        doAccess(1'b0, 4'h0,   32'h0000_0000, 32'h0,         "t4_word0_reread");
        doAccess(1'b1, WEN_SW, 32'h0000_0FFC, 32'h5A5A_A5A5, "t4_last_word_store");
        doAccess(1'b0, 4'h0,   32'h0000_0FFC, 32'h0,         "t4_last_word_load");
        doAccess(1'b0, 4'h0,   32'h8000_0000, 32'h0,         "t4_top_bit_load");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [5] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0FFC,
                                   32'h0000_0040, 32'h0000_0008};
        int idx;
        logic [31:0] expRd;
        sel = 1'b1;
        for (int i = 0; i < 5; i++)
            doAccess(1'b1, WEN_SW, addrs[i], $urandom, "t3_preload");
        @(negedge clk);
        req = 1'b1; wr = 1'b0; wen = 4'h0; addr = addrs[0];
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            totalCnt++;
            if (c % 2 == 0) begin
                if ({addrOk, dataOk, stall} !== 3'b101)
                    $display("FAIL t3_b2b_idle c%0d: {addr_ok,data_ok,stall}=%b want 101",
                             c, {addrOk, dataOk, stall});
                else passCnt++;
            end else begin
                expRd = modelMem[1][addrs[idx][11:2]];
                if ({addrOk, dataOk, stall} !== 3'b010 || rdata !== expRd)
                    $display("FAIL t3_b2b_resp c%0d: {addr_ok,data_ok,stall}=%b rdata=%h want 010 %h",
                             c, {addrOk, dataOk, stall}, rdata, expRd);
                else passCnt++;
                idx++;
                addr = addrs[idx];
            end
            @(negedge clk);
        end
        req = 1'b0;
        lastRdata[1] = modelMem[1][addrs[3][11:2]];
        lastValid[1] = 1'b1;
    endtask

    task automatic test_reset_inflight();
        sel = 1'b0;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; wen = WEN_SW; addr = 32'h0000_0100; wdata = 32'hDEAD_BEEF;
        #1;
        totalCnt++;
        if (addrOk !== 1'b1) $display("FAIL t5_accept: addr_ok_o=%b want 1", addrOk);
        else passCnt++;
        @(negedge clk);
        req = 1'b0;
        #1;
        totalCnt++;
        if (stall !== 1'b1) $display("FAIL t5_wait_stall: stall_o=%b want 1", stall);
        else passCnt++;
        #2 rst = 1'b0;
        #1;
        totalCnt++;
        if ({addrOk, dataOk, err, stall} !== 4'b0000 || rdata !== 32'h0)
            $display("FAIL t5_async_reset: {addr_ok,data_ok,err,stall}=%b rdata=%h want 0000 0",
                     {addrOk, dataOk, err, stall}, rdata);
        else passCnt++;
        @(negedge clk);
        rst = 1'b1;
        lastRdata[0] = 32'h0; lastRdata[1] = 32'h0;
        lastValid[0] = 1'b1;  lastValid[1] = 1'b1;
        // The discarded store must not have reached the array.
        doAccess(1'b0, 4'h0, 32'h0000_0100, 32'h0, "t5_old_value");
    endtask

    task automatic test_req_drop();
        logic [2:0] expTab [4] = '{3'b101, 3'b001, 3'b001, 3'b010};  // {addr_ok,data_ok,stall}
        bit         reqTab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] expRd;
        sel = 1'b0;
        expRd = modelMem[0][10'h3FF];
        @(negedge clk);
        wr = 1'b0; wen = 4'h0; addr = 32'h0000_0FFC;
        for (int c = 0; c < 4; c++) begin
            req = reqTab[c];
            if (c == 2) begin
                // A different store request during WAIT must be ignored.
                wr = 1'b1; wen = WEN_SW; addr = 32'h0000_0100; wdata = 32'h0BAD_0BAD;
            end
            #1;
            totalCnt++;
            if ({addrOk, dataOk, stall} !== expTab[c])
                $display("FAIL t6_drop c%0d: {addr_ok,data_ok,stall}=%b want %b",
                         c, {addrOk, dataOk, stall}, expTab[c]);
            else passCnt++;
            @(negedge clk);
        end
        req = 1'b0;
        totalCnt++;
        #1;
        if (rdata !== expRd) $display("FAIL t6_rdata_held: got %h want %h", rdata, expRd);
        else passCnt++;
        lastRdata[0] = expRd;
        lastValid[0] = 1'b1;
        doAccess(1'b0, 4'h0, 32'h0000_0100, 32'h0, "t6_ignored_store");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  m;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 8; w++)
                doAccess(1'b1, WEN_SW, 32'h0000_0200 + 32'(4 * w), $urandom, "rnd_init");
        end
        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
            else a = 32'h0000_0200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       m = WEN_SB << $urandom_range(0, 3);
                1:       m = WEN_SH << (2 * $urandom_range(0, 1));
                2:       m = WEN_SW;
                default: m = 4'($urandom);
            endcase
            doAccess(1'($urandom_range(0, 1)), m, a, $urandom, "rnd");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_out_of_range();
        test_back_to_back();
        test_reset_inflight();
        test_req_drop();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
